// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Groups the hazard-source inputs and the per-stage strobe outputs of the
// pipeline stall/flush scheduler into one bundle.
//
// Signals (seen from the scheduler, i.e. the slave modport):
//   i_PCTL_loadUse    in  : DEC instruction sources a load destination in EXE
//   i_PCTL_mdUse      in  : DEC instruction is MFHI/MFLO
//   i_PCTL_brTaken    in  : EXE resolved a taken branch/jump
//   i_PCTL_mdStart    in  : EXE holds MULT/DIV (level, held while paused)
//   i_PCTL_mdIsDiv    in  : qualifies mdStart, 1 = divide
//   i_PCTL_iMemReady  in  : instruction fetch completes this cycle
//   i_PCTL_dMemReq    in  : MEM holds a load/store
//   i_PCTL_dMemReady  in  : data access completes this cycle
//   o_PCTL_pause*     out : hold IF/DEC/EXE/MEM pipeline register
//   o_PCTL_clr*       out : load a bubble into DEC/EXE/MEM/WB register
//   o_PCTL_mdGo       out : mul/div unit accepts operands this cycle
//   o_PCTL_mdBusy     out : mul/div unit occupied
//   o_PCTL_mdDone     out : HI/LO valid from next cycle (one-cycle pulse)
//   o_PCTL_dWait      out : data-memory FSM is in DWAIT
// -----------------------------------------------------------------------------
interface pipe_ctrl_if;
    logic i_PCTL_loadUse;
    logic i_PCTL_mdUse;
    logic i_PCTL_brTaken;
    logic i_PCTL_mdStart;
    logic i_PCTL_mdIsDiv;
    logic i_PCTL_iMemReady;
    logic i_PCTL_dMemReq;
    logic i_PCTL_dMemReady;

    logic o_PCTL_pauseIF;
    logic o_PCTL_pauseDEC;
    logic o_PCTL_pauseEXE;
    logic o_PCTL_pauseMEM;
    logic o_PCTL_clrDEC;
    logic o_PCTL_clrEXE;
    logic o_PCTL_clrMEM;
    logic o_PCTL_clrWB;
    logic o_PCTL_mdGo;
    logic o_PCTL_mdBusy;
    logic o_PCTL_mdDone;
    logic o_PCTL_dWait;

    // Pipeline / hazard-detection side: drives hazard sources, consumes strobes
    modport master (
        output i_PCTL_loadUse, i_PCTL_mdUse, i_PCTL_brTaken, i_PCTL_mdStart,
               i_PCTL_mdIsDiv, i_PCTL_iMemReady, i_PCTL_dMemReq, i_PCTL_dMemReady,
        input  o_PCTL_pauseIF, o_PCTL_pauseDEC, o_PCTL_pauseEXE, o_PCTL_pauseMEM,
               o_PCTL_clrDEC, o_PCTL_clrEXE, o_PCTL_clrMEM, o_PCTL_clrWB,
               o_PCTL_mdGo, o_PCTL_mdBusy, o_PCTL_mdDone, o_PCTL_dWait
    );

    // Scheduler side
    modport slave (
        input  i_PCTL_loadUse, i_PCTL_mdUse, i_PCTL_brTaken, i_PCTL_mdStart,
               i_PCTL_mdIsDiv, i_PCTL_iMemReady, i_PCTL_dMemReq, i_PCTL_dMemReady,
        output o_PCTL_pauseIF, o_PCTL_pauseDEC, o_PCTL_pauseEXE, o_PCTL_pauseMEM,
               o_PCTL_clrDEC, o_PCTL_clrEXE, o_PCTL_clrMEM, o_PCTL_clrWB,
               o_PCTL_mdGo, o_PCTL_mdBusy, o_PCTL_mdDone, o_PCTL_dWait
    );
endinterface

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central stall/flush scheduler for the five-stage pipeline. Merges data-memory
// wait, mul/div structural hazard, taken branch, load-use / HI-LO use and
// instruction-fetch wait into one prioritised set of pause/clear strobes.
// Owns the mul/div occupancy counter and the data-memory wait FSM.
//
// Ports:
//   clk   : pipeline clock, all state changes on the rising edge
//   rst   : synchronous active-high reset
//   pctl  : pipe_ctrl_if.slave bundle (hazard inputs, stage strobes)
//
// Strobes are combinational from inputs and registered state; stage registers
// act on them at the next edge.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic           clk,
    input  logic           rst,
    pipe_ctrl_if.slave     pctl
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DWAIT = 1'b1
    } dstate_t;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES);

    dstate_t    dstate_q;
    dstate_t    dstate_d;
    logic [5:0] md_cnt_q;
    logic [5:0] md_cnt_d;

    logic       dwait_s;
    logic       md_busy_s;
    logic       md_go_s;
    logic       md_done_s;

    // Occupancy of the iterative unit, derived from the counter.
    assign md_busy_s = (md_cnt_q != 6'd0);
    assign md_done_s = (md_cnt_q == 6'd1);

    // Data-memory stall condition: asserted already in the request cycle so
    // that entering DWAIT costs no extra cycle.
    always_comb begin
        dwait_s = 1'b0;
        case (dstate_q)
            RUN:     dwait_s = pctl.i_PCTL_dMemReq & ~pctl.i_PCTL_dMemReady;
            DWAIT:   dwait_s = ~pctl.i_PCTL_dMemReady;
            default: dwait_s = 1'b0;
        endcase
    end

    // Data-memory FSM next state.
    always_comb begin
        dstate_d = dstate_q;
        case (dstate_q)
            RUN: begin
                if (pctl.i_PCTL_dMemReq && !pctl.i_PCTL_dMemReady) begin
                    dstate_d = DWAIT;
                end else begin
                    dstate_d = RUN;
                end
            end
            DWAIT: begin
                if (pctl.i_PCTL_dMemReady) begin
                    dstate_d = RUN;
                end else begin
                    dstate_d = DWAIT;
                end
            end
            default: dstate_d = RUN;
        endcase
    end

    // A new MULT/DIV is accepted only when the unit is free and MEM is not
    // waiting (EXE is frozen during a data wait).
    assign md_go_s = pctl.i_PCTL_mdStart & ~md_busy_s & ~dwait_s;

    // Mul/div counter next state: load on start, otherwise count down to 0.
    // It keeps counting during data waits; only new starts are blocked.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_go_s) begin
            if (pctl.i_PCTL_mdIsDiv) begin
                md_cnt_d = DIV_LOAD;
            end else begin
                md_cnt_d = MUL_LOAD;
            end
        end else if (md_busy_s) begin
            md_cnt_d = md_cnt_q - 6'd1;
        end else begin
            md_cnt_d = 6'd0;
        end
    end

    // Prioritised strobe generation; first matching hazard wins.
    always_comb begin
        pctl.o_PCTL_pauseIF  = 1'b0;
        pctl.o_PCTL_pauseDEC = 1'b0;
        pctl.o_PCTL_pauseEXE = 1'b0;
        pctl.o_PCTL_pauseMEM = 1'b0;
        pctl.o_PCTL_clrDEC   = 1'b0;
        pctl.o_PCTL_clrEXE   = 1'b0;
        pctl.o_PCTL_clrMEM   = 1'b0;
        pctl.o_PCTL_clrWB    = 1'b0;
        pctl.o_PCTL_mdGo     = 1'b0;
        pctl.o_PCTL_mdBusy   = 1'b0;
        pctl.o_PCTL_mdDone   = 1'b0;
        pctl.o_PCTL_dWait    = 1'b0;

        if (rst) begin
            // Flush everything downstream of IF while reset is held.
            pctl.o_PCTL_clrDEC = 1'b1;
            pctl.o_PCTL_clrEXE = 1'b1;
            pctl.o_PCTL_clrMEM = 1'b1;
            pctl.o_PCTL_clrWB  = 1'b1;
        end else begin
            pctl.o_PCTL_mdGo   = md_go_s;
            pctl.o_PCTL_mdBusy = md_busy_s;
            pctl.o_PCTL_mdDone = md_done_s;
            pctl.o_PCTL_dWait  = (dstate_q == DWAIT);

            if (dwait_s) begin
                // Whole front of the pipe frozen; a taken branch in EXE simply
                // re-presents once the wait ends.
                pctl.o_PCTL_pauseIF  = 1'b1;
                pctl.o_PCTL_pauseDEC = 1'b1;
                pctl.o_PCTL_pauseEXE = 1'b1;
                pctl.o_PCTL_pauseMEM = 1'b1;
                pctl.o_PCTL_clrWB    = 1'b1;
            end else if (pctl.i_PCTL_mdStart && md_busy_s) begin
                pctl.o_PCTL_pauseIF  = 1'b1;
                pctl.o_PCTL_pauseDEC = 1'b1;
                pctl.o_PCTL_pauseEXE = 1'b1;
                pctl.o_PCTL_clrMEM   = 1'b1;
            end else if (pctl.i_PCTL_brTaken) begin
                // Both younger instructions are squashed, so load-use and
                // HI/LO hazards in DEC are moot.
                pctl.o_PCTL_clrDEC  = 1'b1;
                pctl.o_PCTL_clrEXE  = 1'b1;
                pctl.o_PCTL_pauseIF = ~pctl.i_PCTL_iMemReady;
            end else if (pctl.i_PCTL_loadUse ||
                         (pctl.i_PCTL_mdUse && (md_busy_s || md_go_s))) begin
                pctl.o_PCTL_pauseIF  = 1'b1;
                pctl.o_PCTL_pauseDEC = 1'b1;
                pctl.o_PCTL_clrEXE   = 1'b1;
            end else if (!pctl.i_PCTL_iMemReady) begin
                pctl.o_PCTL_pauseIF = 1'b1;
                pctl.o_PCTL_clrDEC  = 1'b1;
            end else begin
                pctl.o_PCTL_pauseIF = 1'b0;
            end
        end
    end

    // State registers with synchronous reset; reset abandons any divide and
    // any pending memory wait without a completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            dstate_q <= RUN;
            md_cnt_q <= 6'd0;
        end else begin
            dstate_q <= dstate_d;
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Table-driven bench for pipe_ctrl. Each vector drives one cycle of inputs;
// its expected strobes go into a scoreboard queue when driven and are popped
// and compared at the falling edge of the same cycle.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    // Input packing: {rst, loadUse, mdUse, brTaken, mdStart, mdIsDiv,
    //                 iMemReady, dMemReq, dMemReady}
    localparam logic [8:0] I_RST  = 9'b1_0000_0000;
    localparam logic [8:0] I_LU   = 9'b0_1000_0000;
    localparam logic [8:0] I_MDU  = 9'b0_0100_0000;
    localparam logic [8:0] I_BR   = 9'b0_0010_0000;
    localparam logic [8:0] I_MDS  = 9'b0_0001_0000;
    localparam logic [8:0] I_DIV  = 9'b0_0000_1000;
    localparam logic [8:0] I_IMR  = 9'b0_0000_0100;
    localparam logic [8:0] I_DREQ = 9'b0_0000_0010;
    localparam logic [8:0] I_DRDY = 9'b0_0000_0001;

    // Output packing: {pIF,pDEC,pEXE,pMEM, cDEC,cEXE,cMEM,cWB, go,busy,done,dWait}
    localparam logic [11:0] E_PIF  = 12'h800;
    localparam logic [11:0] E_PDEC = 12'h400;
    localparam logic [11:0] E_PEXE = 12'h200;
    localparam logic [11:0] E_PMEM = 12'h100;
    localparam logic [11:0] E_CDEC = 12'h080;
    localparam logic [11:0] E_CEXE = 12'h040;
    localparam logic [11:0] E_CMEM = 12'h020;
    localparam logic [11:0] E_CWB  = 12'h010;
    localparam logic [11:0] E_GO   = 12'h008;
    localparam logic [11:0] E_BUSY = 12'h004;
    localparam logic [11:0] E_DONE = 12'h002;
    localparam logic [11:0] E_DW   = 12'h001;
    localparam logic [11:0] E_NONE = 12'h000;

    localparam logic [11:0] E_RESET = E_CDEC | E_CEXE | E_CMEM | E_CWB;
    localparam logic [11:0] E_DSTL  = E_PIF | E_PDEC | E_PEXE | E_PMEM | E_CWB;
    localparam logic [11:0] E_STRC  = E_PIF | E_PDEC | E_PEXE | E_CMEM;
    localparam logic [11:0] E_USE   = E_PIF | E_PDEC | E_CEXE;

    typedef struct {
        string       name;
        logic [8:0]  in;
        logic [11:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [11:0] exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if pif ();

    pipe_ctrl #(
        .MUL_CYCLES(4),
        .DIV_CYCLES(32)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .pctl (pif)
    );

    function automatic void add(input string n, input logic [8:0] i, input logic [11:0] e);
        vec_t v;
        v.name = n;
        v.in   = i;
        v.exp  = e;
        vecs.push_back(v);
    endfunction

    function automatic logic [11:0] dut_out();
        return {pif.o_PCTL_pauseIF, pif.o_PCTL_pauseDEC, pif.o_PCTL_pauseEXE,
                pif.o_PCTL_pauseMEM, pif.o_PCTL_clrDEC, pif.o_PCTL_clrEXE,
                pif.o_PCTL_clrMEM, pif.o_PCTL_clrWB, pif.o_PCTL_mdGo,
                pif.o_PCTL_mdBusy, pif.o_PCTL_mdDone, pif.o_PCTL_dWait};
    endfunction

    task automatic drive(input logic [8:0] i);
        rst                  = i[8];
        pif.i_PCTL_loadUse   = i[7];
        pif.i_PCTL_mdUse     = i[6];
        pif.i_PCTL_brTaken   = i[5];
        pif.i_PCTL_mdStart   = i[4];
        pif.i_PCTL_mdIsDiv   = i[3];
        pif.i_PCTL_iMemReady = i[2];
        pif.i_PCTL_dMemReq   = i[1];
        pif.i_PCTL_dMemReady = i[0];
    endtask

    initial begin
        // ---------------- reset ----------------
        add("rst0", I_RST | I_DREQ | I_MDS | I_IMR, E_RESET);
        add("rst1", I_RST | I_DREQ | I_MDS | I_IMR, E_RESET);
        add("post_rst_idle", I_IMR, E_NONE);

        // ---------------- divide then MFHI ----------------
        add("div_go", I_IMR | I_MDS | I_DIV, E_GO);
        for (int k = 0; k < 32; k++) begin
            add($sformatf("div_mfhi_%0d", k), I_IMR | I_MDU,
                E_USE | E_BUSY | ((k == 31) ? E_DONE : E_NONE));
        end
        add("div_mfhi_release", I_IMR | I_MDU, E_NONE);
        add("idle_a", I_IMR, E_NONE);

        // ---------------- back-to-back MULT ----------------
        add("mul1_go", I_IMR | I_MDS, E_GO);
        for (int k = 1; k <= 4; k++) begin
            add($sformatf("mul_struct_%0d", k), I_IMR | I_MDS,
                E_STRC | E_BUSY | ((k == 4) ? E_DONE : E_NONE));
        end
        add("mul2_go", I_IMR | I_MDS, E_GO);
        for (int k = 1; k <= 4; k++) begin
            add($sformatf("mul2_busy_%0d", k), I_IMR,
                E_BUSY | ((k == 4) ? E_DONE : E_NONE));
        end
        add("idle_b", I_IMR, E_NONE);

        // ---------------- data wait with branch during the wait ----------------
        add("dw_req", I_IMR | I_DREQ, E_DSTL);
        add("dw_br1", I_IMR | I_DREQ | I_BR, E_DSTL | E_DW);
        add("dw_br2", I_IMR | I_DREQ | I_BR, E_DSTL | E_DW);
        add("dw_ready_br", I_IMR | I_DREQ | I_DRDY | I_BR, E_CDEC | E_CEXE | E_DW);
        add("dw_run", I_IMR, E_NONE);

        // ---------------- request and ready together ----------------
        add("dreq_rdy_same", I_IMR | I_DREQ | I_DRDY, E_NONE);
        add("dreq_rdy_after", I_IMR, E_NONE);

        // ---------------- branch vs load-use / fetch miss ----------------
        add("br_lu_imiss", I_BR | I_LU, E_PIF | E_CDEC | E_CEXE);
        add("br_hit", I_BR | I_IMR | I_MDU, E_CDEC | E_CEXE);
        add("loaduse", I_LU | I_IMR, E_USE);
        add("lu_imiss", I_LU, E_USE);

        // ---------------- fetch miss during a MULT ----------------
        add("imiss_mul_go", I_IMR | I_MDS, E_GO);
        add("imiss_0", 9'd0, E_PIF | E_CDEC | E_BUSY);
        add("imiss_1", 9'd0, E_PIF | E_CDEC | E_BUSY);
        add("imiss_2", 9'd0, E_PIF | E_CDEC | E_BUSY);
        add("imiss_done", I_IMR, E_BUSY | E_DONE);
        add("imiss_end", I_IMR, E_NONE);

        // ---------------- counter runs on through a data wait ----------------
        add("dwmd_go", I_IMR | I_MDS, E_GO);
        add("dwmd_4", I_IMR | I_MDS | I_DREQ, E_DSTL | E_BUSY);
        add("dwmd_3", I_IMR | I_MDS | I_DREQ, E_DSTL | E_BUSY | E_DW);
        add("dwmd_2", I_IMR | I_MDS | I_DREQ, E_DSTL | E_BUSY | E_DW);
        add("dwmd_1", I_IMR | I_MDS | I_DREQ, E_DSTL | E_BUSY | E_DONE | E_DW);
        add("dwmd_blocked", I_IMR | I_MDS | I_DREQ, E_DSTL | E_DW);
        add("dwmd_go2", I_IMR | I_MDS | I_DREQ | I_DRDY, E_GO | E_DW);
        // reset in the middle of that MULT, with a new wait pending
        add("midop_rst", I_RST | I_IMR | I_DREQ, E_RESET);
        add("midop_after", I_IMR, E_NONE);
        add("midop_after2", I_IMR, E_NONE);

        // ---------------- MFHI in DEC while MULT starts in EXE ----------------
        add("mdu_with_go", I_IMR | I_MDS | I_MDU, E_USE | E_GO);
        add("mdu_busy4", I_IMR, E_BUSY);
        add("mdu_busy3", I_IMR, E_BUSY);
        add("mdu_busy2", I_IMR, E_BUSY);
        add("mdu_busy1", I_IMR, E_BUSY | E_DONE);
        add("final_idle", I_IMR, E_NONE);

        // ---------------- run ----------------
        drive(I_RST | I_IMR);
        foreach (vecs[i]) begin
            sb_t e;
            logic [11:0] act;
            @(posedge clk);
            #1;
            drive(vecs[i].in);
            e.name = vecs[i].name;
            e.exp  = vecs[i].exp;
            sb_q.push_back(e);
            @(negedge clk);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got empty queue, required an entry");
            end else begin
                e   = sb_q.pop_front();
                act = dut_out();
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %03h required %03h", e.name, act, e.exp);
                end
            end
        end

        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left required 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
